// File: rtl/data_mem_banked.sv
// data_mem_banked: scan-loaded row memory, word-interleaved over NUM_BANKS banks, NUM_PORTS valid/ready read channels.
// 1-cycle read latency; bank losers stall via ready_out; DATA_MEM_BANKED_RR_EN selects round-robin over fixed priority.
module data_mem_banked #(
  parameter int DATA_W    = 512,
  parameter int DEPTH     = 256,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int NUM_PORTS = 2,
  parameter int NUM_BANKS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          scan_mode,
  input  logic [DATA_W-1:0]             scan_in,
  input  logic [ADDR_W-1:0]             scan_addr,
  input  logic [NUM_PORTS*ADDR_W-1:0]   addr_in,
  input  logic [NUM_PORTS-1:0]          valid_in,
  output logic [NUM_PORTS-1:0]          ready_out,
  output logic [NUM_PORTS*DATA_W-1:0]   data_out,
  output logic [NUM_PORTS*ADDR_W-1:0]   addr_out,
  output logic [NUM_PORTS-1:0]          valid_out
);
  localparam int BW = $clog2(NUM_BANKS);
  localparam int ROWS = DEPTH / NUM_BANKS;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0]           r_mem [NUM_BANKS][ROWS];
  logic [NUM_PORTS-1:0]        r_valid_out;
  logic [NUM_PORTS*DATA_W-1:0] r_data_out;
  logic [NUM_PORTS*ADDR_W-1:0] r_addr_out;

  logic [NUM_PORTS-1:0]        w_granted;
  logic [NUM_PORTS-1:0]        w_ready;
  logic [ADDR_W-1:0]           w_bank_addr [NUM_BANKS];
  logic [DATA_W-1:0]           w_bank_rdat [NUM_BANKS];

`ifdef DATA_MEM_BANKED_RR_EN
  localparam int PW = $clog2(NUM_PORTS);
  logic [PW-1:0] r_rr_ptr;
  logic [PW-1:0] w_next_ptr;
  logic          w_conflict;
`endif

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  always_ff @(posedge clk) begin
    if (scan_mode && in_range(scan_addr)) begin
      r_mem[scan_addr[BW-1:0]][scan_addr[ADDR_W-1:BW]] <= scan_in;
    end
  end

  // Per bank: the first requester in priority order picks the row; equal-address requesters share it.
  always_comb begin : arb
    logic found;
    int   idx;
    w_granted = '0;
    found     = 1'b0;
    idx       = 0;
`ifdef DATA_MEM_BANKED_RR_EN
    w_conflict = 1'b0;
    w_next_ptr = '0;
`endif
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_bank_addr[b] = '0;
      found          = 1'b0;
      for (int k = 0; k < NUM_PORTS; k++) begin
`ifdef DATA_MEM_BANKED_RR_EN
        idx = k + int'(r_rr_ptr);
        if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
`else
        idx = k;
`endif
        if (!found && valid_in[idx] && addr_in[idx*ADDR_W +: BW] == BW'(b)) begin
          found          = 1'b1;
          w_bank_addr[b] = addr_in[idx*ADDR_W +: ADDR_W];
        end
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (valid_in[p] && addr_in[p*ADDR_W +: BW] == BW'(b)) begin
          if (addr_in[p*ADDR_W +: ADDR_W] == w_bank_addr[b]) w_granted[p] = 1'b1;
`ifdef DATA_MEM_BANKED_RR_EN
          else w_conflict = 1'b1;
`endif
        end
      end
    end
`ifdef DATA_MEM_BANKED_RR_EN
    for (int p = NUM_PORTS-1; p >= 0; p--) begin
      if (w_granted[p]) w_next_ptr = (p == NUM_PORTS-1) ? '0 : PW'(p+1);
    end
`endif
  end

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_bank_rdat[b] = in_range(w_bank_addr[b]) ? r_mem[b][w_bank_addr[b][ADDR_W-1:BW]] : '0;
    end
  end

  assign w_ready = {NUM_PORTS{reset && !scan_mode}} & valid_in & w_granted;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid_out <= '0;
      r_data_out  <= '0;
      r_addr_out  <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_valid_out[p] <= w_ready[p];
        if (w_ready[p]) begin
          r_data_out[p*DATA_W +: DATA_W] <= w_bank_rdat[addr_in[p*ADDR_W +: BW]];
          r_addr_out[p*ADDR_W +: ADDR_W] <= addr_in[p*ADDR_W +: ADDR_W];
        end
      end
    end
  end

`ifdef DATA_MEM_BANKED_RR_EN
  always_ff @(posedge clk) begin
    if (!reset) r_rr_ptr <= '0;
    else if (!scan_mode && w_conflict) r_rr_ptr <= w_next_ptr;
  end
`endif

  assign ready_out = w_ready;
  assign valid_out = r_valid_out;
  assign data_out  = r_data_out;
  assign addr_out  = r_addr_out;
endmodule

// File: tb/tb_data_mem_banked.sv
// Bench for data_mem_banked: directed scenarios plus randomized traffic against a behavioural model.
module tb_data_mem_banked;
  localparam int DW = 64, DEPTH = 200, AW = 8, NP = 2, NB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, scan_mode;
  logic [DW-1:0] scan_in;
  logic [AW-1:0] scan_addr;
  logic [NP*AW-1:0] addr_in, addr_out;
  logic [NP-1:0] valid_in, ready_out, valid_out;
  logic [NP*DW-1:0] data_out;

  data_mem_banked #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .NUM_PORTS(NP), .NUM_BANKS(NB)) dut (
    .clk(clk), .reset(reset), .scan_mode(scan_mode), .scan_in(scan_in), .scan_addr(scan_addr),
    .addr_in(addr_in), .valid_in(valid_in), .ready_out(ready_out), .data_out(data_out),
    .addr_out(addr_out), .valid_out(valid_out)
  );

  int checks = 0, errors = 0;

  // Behavioural model state
  logic [DW-1:0] m_mem [DEPTH];
  logic [NP-1:0] m_vld;
  logic [DW-1:0] m_dat [NP];
  logic [AW-1:0] m_addr [NP];
  int            m_ptr;
  logic [NP-1:0] smp_rdy;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive at negedge, check ready combinationally, clock, check registered outputs.
  task automatic cyc(input bit rst_n, input bit scan, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                     input logic [NP-1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    logic [AW-1:0] a [NP];
    logic [NP-1:0] g, exp_rdy;
    logic          claimed [NB];
    logic [AW-1:0] owner [NB];
    int            start, p, b, lo;
    a[0] = a0; a[1] = a1;
    reset = rst_n; scan_mode = scan; scan_addr = sa; scan_in = sd;
    valid_in = v; addr_in = {a1, a0};

    g = '0;
    for (int i = 0; i < NB; i++) begin claimed[i] = 1'b0; owner[i] = '0; end
`ifdef DATA_MEM_BANKED_RR_EN
    start = m_ptr;
`else
    start = 0;
`endif
    for (int k = 0; k < NP; k++) begin
      p = (start + k) % NP;
      if (v[p]) begin
        b = int'(a[p]) % NB;
        if (!claimed[b]) begin
          claimed[b] = 1'b1; owner[b] = a[p]; g[p] = 1'b1;
        end else if (owner[b] == a[p]) begin
          g[p] = 1'b1;
        end
      end
    end
    exp_rdy = (rst_n && !scan) ? (v & g) : '0;

    #1;
    smp_rdy = ready_out;
    check_val("ready", DW'(ready_out), DW'(exp_rdy));

    @(posedge clk);
    if (!rst_n) begin
      m_vld = '0; m_ptr = 0;
      for (int i = 0; i < NP; i++) begin m_dat[i] = '0; m_addr[i] = '0; end
    end else begin
      for (int i = 0; i < NP; i++) begin
        m_vld[i] = exp_rdy[i];
        if (exp_rdy[i]) begin
          m_dat[i]  = (int'(a[i]) < DEPTH) ? m_mem[a[i]] : '0;
          m_addr[i] = a[i];
        end
      end
      if (scan && int'(sa) < DEPTH) m_mem[sa] = sd;
`ifdef DATA_MEM_BANKED_RR_EN
      if (!scan && (v & ~g) != '0) begin
        lo = NP;
        for (int i = NP-1; i >= 0; i--) if (g[i]) lo = i;
        m_ptr = (lo + 1) % NP;
      end
`endif
    end

    @(negedge clk);
    check_val("valid_out", DW'(valid_out), DW'(m_vld));
    for (int i = 0; i < NP; i++) begin
      check_val($sformatf("data_out%0d", i), data_out[i*DW +: DW], m_dat[i]);
      check_val($sformatf("addr_out%0d", i), DW'(addr_out[i*AW +: AW]), DW'(m_addr[i]));
    end
  endtask

  logic [NP-1:0] prev_v;
  logic [AW-1:0] prev_a [NP];
  logic [NP-1:0] nv;
  logic [AW-1:0] na [NP];

  initial begin
    reset = 1'b0; scan_mode = 1'b0; scan_in = '0; scan_addr = '0; addr_in = '0; valid_in = '0;
    m_vld = '0; m_ptr = 0;
    for (int i = 0; i < NP; i++) begin m_dat[i] = '0; m_addr[i] = '0; end
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    @(negedge clk);

    // Reset with requests pending: ready forced low, outputs cleared
    cyc(0, 0, 0, 0, 2'b11, 8'd1, 8'd2);
    cyc(0, 0, 0, 0, 2'b11, 8'd1, 8'd2);
    check_val("rst_rdy", DW'(smp_rdy), '0);

    // Load rows; first load cycle also checks lockout
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, 1, AW'(i), (i < 20) ? DW'(i + 1) : '0, (i == 0) ? 2'b11 : 2'b00, 8'd5, 8'd10);
      if (i == 0) begin
        check_val("lock_rdy", DW'(smp_rdy), '0);
        check_val("lock_vld", DW'(valid_out), '0);
      end
    end
    cyc(1, 1, 8'hF0, 64'hDEAD, 2'b00, 0, 0);

    // Parallel read, different banks
    cyc(1, 0, 0, 0, 2'b11, 8'd5, 8'd10);
    check_val("par_rdy", DW'(smp_rdy), DW'(2'b11));
    check_val("par_d0", data_out[DW-1:0], 64'd6);
    check_val("par_d1", data_out[2*DW-1:DW], 64'd11);
    check_val("par_vld", DW'(valid_out), DW'(2'b11));

    // Broadcast of one row to both channels
    cyc(1, 0, 0, 0, 2'b11, 8'd9, 8'd9);
    check_val("bc_rdy", DW'(smp_rdy), DW'(2'b11));
    check_val("bc_d0", data_out[DW-1:0], 64'd10);
    check_val("bc_d1", data_out[2*DW-1:DW], 64'd10);

    // Bank conflict: ch0 wins first, ch1 served once ch0 is done
    cyc(1, 0, 0, 0, 2'b11, 8'd1, 8'd5);
    check_val("conf_rdy", DW'(smp_rdy), DW'(2'b01));
    check_val("conf_d0", data_out[DW-1:0], 64'd2);
    cyc(1, 0, 0, 0, 2'b10, 8'd1, 8'd5);
    check_val("conf2_rdy", DW'(smp_rdy), DW'(2'b10));
    check_val("conf2_d1", data_out[2*DW-1:DW], 64'd6);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 2'b11, 8'd1, 8'd5);

    // Withdraw a stalled request
    cyc(1, 0, 0, 0, 2'b11, 8'd2, 8'd6);
    cyc(1, 0, 0, 0, 2'b00, 8'd2, 8'd6);
    check_val("wd_vld", DW'(valid_out), '0);

    // Scan rising with a read in flight, then write-to-read ordering
    cyc(1, 0, 0, 0, 2'b01, 8'd7, 8'd0);
    check_val("inflight_d0", data_out[DW-1:0], 64'd8);
    cyc(1, 1, 8'd3, 64'hAB, 2'b11, 8'd3, 8'd4);
    check_val("scan_vld", DW'(valid_out), '0);
    cyc(1, 0, 0, 0, 2'b01, 8'd3, 8'd0);
    check_val("wr_rd_d0", data_out[DW-1:0], 64'hAB);

    // Out-of-range read (and the dropped write at 0xF0)
    cyc(1, 0, 0, 0, 2'b01, 8'hF0, 8'd0);
    check_val("oor_rdy", DW'(smp_rdy), DW'(2'b01));
    check_val("oor_d0", data_out[DW-1:0], '0);
    check_val("oor_a0", DW'(addr_out[AW-1:0]), DW'(8'hF0));

    // Mid-run reset during a stream
    cyc(1, 0, 0, 0, 2'b11, 8'd5, 8'd10);
    cyc(1, 0, 0, 0, 2'b11, 8'd11, 8'd12);
    cyc(0, 0, 0, 0, 2'b11, 8'd13, 8'd14);
    check_val("mrst_rdy", DW'(smp_rdy), '0);
    check_val("mrst_d0", data_out[DW-1:0], '0);
    cyc(1, 0, 0, 0, 2'b11, 8'd5, 8'd10);
    check_val("post_d0", data_out[DW-1:0], 64'd6);
    check_val("post_d1", data_out[2*DW-1:DW], 64'd11);

    // Randomized traffic: holds stalled requests most of the time
    prev_v = '0;
    for (int i = 0; i < NP; i++) prev_a[i] = '0;
    for (int n = 0; n < 600; n++) begin
      int r;
      r = $urandom_range(0, 99);
      for (int i = 0; i < NP; i++) begin
        if (prev_v[i] && !smp_rdy[i] && ($urandom % 4) != 0) begin
          nv[i] = 1'b1; na[i] = prev_a[i];
        end else begin
          nv[i] = 1'($urandom % 2);
          na[i] = (($urandom % 8) != 0) ? AW'($urandom_range(0, 23)) : AW'($urandom_range(190, 255));
        end
      end
      if (r < 3)
        cyc(0, 0, 0, 0, nv, na[0], na[1]);
      else if (r < 10)
        cyc(1, 1, AW'($urandom_range(0, 219)), {$urandom, $urandom}, nv, na[0], na[1]);
      else
        cyc(1, 0, 0, 0, nv, na[0], na[1]);
      prev_v = nv;
      for (int i = 0; i < NP; i++) prev_a[i] = na[i];
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
